// File: rtl/ccr_pkg.sv
// Shared condition-code definitions for the 8-bit pipeline.
// Flag indices and default sizes used by branch, control and ccr units.
package ccr_pkg;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    localparam int CCR_FLAG_W = 4;
    localparam int CCR_DEPTH  = 4;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_SWAP
    } lifo_op_t;

endpackage

// File: rtl/ccr_lifo.sv
// Flag save area: LIFO with push/pop/swap, occupancy count
// and sticky overflow/underflow detection.
module ccr_lifo
    import ccr_pkg::*;
#(
    parameter int FLAG_W = CCR_FLAG_W,
    parameter int DEPTH  = CCR_DEPTH,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save,
    input  logic              restore,
    input  logic              err_clr,
    input  logic [FLAG_W-1:0] wr_data,
    output logic [FLAG_W-1:0] top,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              load,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] mem [DEPTH];
    logic [LVL_W-1:0]  top_lvl;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;
    lifo_op_t          op;
    logic              ovf_set;
    logic              unf_set;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign top_lvl = level - LVL_W'(1);
    assign top_idx = top_lvl[IDX_W-1:0];
    assign wr_idx  = level[IDX_W-1:0];
    assign top     = mem[top_idx];
    assign load    = (op == OP_POP) || (op == OP_SWAP);

    // Save+restore on an empty stack degrades to a plain save.
    always_comb begin
        op      = OP_NONE;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (1'b1)
            save && restore && !empty:
                op = OP_SWAP;
            save && (!restore || empty) && !full:
                op = OP_PUSH;
            save && !restore && full:
                ovf_set = 1'b1;
            !save && restore && !empty:
                op = OP_POP;
            !save && restore && empty:
                unf_set = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            unique case (op)
                OP_PUSH: level <= level + LVL_W'(1);
                OP_POP:  level <= top_lvl;
                default: ;
            endcase
            ovf_err <= ovf_set | (ovf_err & ~err_clr);
            unf_err <= unf_set | (unf_err & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            unique case (op)
                OP_PUSH: mem[wr_idx]  <= wr_data;
                OP_SWAP: mem[top_idx] <= wr_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ccr_stack.sv
// Condition-code register with masked update and nested save area.
// Restore/swap take priority over the per-bit write mask.
module ccr_stack
    import ccr_pkg::*;
#(
    parameter int FLAG_W = CCR_FLAG_W,
    parameter int DEPTH  = CCR_DEPTH,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLAG_W-1:0] FLAGS_IN,
    input  logic [FLAG_W-1:0] FLAG_WE,
    input  logic              F_SAVE,
    input  logic              F_RESTORE,
    input  logic              ERR_CLR,
    output logic [FLAG_W-1:0] OUT,
    output logic [LVL_W-1:0]  LEVEL,
    output logic              STACK_FULL,
    output logic              STACK_EMPTY,
    output logic              OVF_ERR,
    output logic              UNF_ERR
);

    logic [FLAG_W-1:0] top;
    logic              load;

    ccr_lifo #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_lifo (
        .clk     (CLK),
        .rst     (RST),
        .save    (F_SAVE),
        .restore (F_RESTORE),
        .err_clr (ERR_CLR),
        .wr_data (OUT),
        .top     (top),
        .level   (LEVEL),
        .full    (STACK_FULL),
        .empty   (STACK_EMPTY),
        .load    (load),
        .ovf_err (OVF_ERR),
        .unf_err (UNF_ERR)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT <= '0;
        end else if (load) begin
            OUT <= top;
        end else begin
            OUT <= (OUT & ~FLAG_WE) | (FLAGS_IN & FLAG_WE);
        end
    end

endmodule

// File: doc/ccr_stack.md
Name: ccr_stack

Overview:
- Parametrised condition-code register with a LIFO save area of configurable depth. It supports nested interrupt/call flag preservation.
- Sits in the execute/writeback boundary of the 8-bit pipelined processor. It receives ALU flags and save/restore strobes from the control unit, and drives the flag bus consumed by branch logic.
- Adds over the single-level flag register:
  - per-flag write masking
  - multi-level stack
  - registered restore
  - occupancy reporting
  - sticky overflow/underflow errors

Parameters:
FLAG_W, 4, number of flag bits (bit0 Z, bit1 N, bit2 C, bit3 V for default)
DEPTH, 4, number of stacked flag entries (>=1)
LVL_W, $clog2(DEPTH+1), width of occupancy count

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
FLAGS_IN  input  FLAG_W  new flags from ALU
FLAG_WE  input  FLAG_W  per-bit update mask; 1 = load FLAGS_IN bit
F_SAVE  input  1  push current flags onto stack
F_RESTORE  input  1  pop top of stack into current flags
ERR_CLR  input  1  clear sticky error bits
OUT  output  FLAG_W  current flags (registered)
LEVEL  output  LVL_W  number of valid stacked entries
STACK_FULL  output  1  LEVEL == DEPTH
STACK_EMPTY  output  1  LEVEL == 0
OVF_ERR  output  1  sticky: save attempted while full
UNF_ERR  output  1  sticky: restore attempted while empty

Behaviour:
- Clocking and reset:
  - Single clock domain, all state updates on rising CLK.
  - RST is sampled on the rising edge. When high, it sets OUT=0, LEVEL=0, OVF_ERR=0 and UNF_ERR=0, and marks all stack entries invalid. Contents need not be cleared.
  - RST overrides every other input on the same edge. Reset mid-sequence discards all stacked levels.
- Flag update (no save/restore): OUT_next[i] = FLAG_WE[i] ? FLAGS_IN[i] : OUT[i]. Latency is 1 cycle and OUT is purely registered.
- Save only (F_SAVE=1, F_RESTORE=0):
  - If not full: stack[LEVEL] <= OUT (pre-update value), LEVEL+1.
  - The masked flag update to OUT still occurs on the same edge.
- Restore only (F_RESTORE=1, F_SAVE=0):
  - If not empty: OUT <= stack[LEVEL-1], LEVEL-1.
  - Restore has priority over FLAG_WE; the masked update is ignored that cycle.
- Save and restore together:
  - If not empty: swap. stack[LEVEL-1] <= OUT and OUT <= old stack[LEVEL-1]; LEVEL is unchanged and FLAG_WE is ignored.
  - If empty: treated as save-only, and UNF_ERR is not set.
- Overflow: F_SAVE (without F_RESTORE) while STACK_FULL:
  - Push is discarded; stack and LEVEL are unchanged.
  - OVF_ERR <= 1; the masked flag update still occurs.
- Underflow: F_RESTORE (without F_SAVE) while STACK_EMPTY:
  - OUT is unchanged by restore, and the masked flag update still occurs.
  - UNF_ERR <= 1.
- Sticky errors:
  - Cleared only by RST or ERR_CLR.
  - If ERR_CLR and a new error event occur on the same edge, the error sets (set wins).
- STACK_FULL and STACK_EMPTY are combinational decodes of the registered LEVEL.
- No wrap-around: the stack never overwrites the oldest entry.
- DEPTH=1 must behave as a single-level save register with the same error rules.

Decomposition:
- Shared package ccr_pkg holds:
  - flag bit index constants FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3
  - default FLAG_W=4 and DEPTH=4 localparams, for use by branch unit and control unit
- One natural sub-module, ccr_lifo:
  - Parametrised FLAG_W x DEPTH storage with push/pop/swap, LEVEL counter, full/empty and error detection.
  - ccr_stack instantiates it and owns the OUT register and FLAG_WE masking.

Test Plan:
- Reset, then FLAGS_IN=4'b1011 with FLAG_WE=4'b0011 -> OUT=4'b0011 one cycle later; upper bits remain 0.
- OUT=4'b0101, pulse F_SAVE with FLAGS_IN=4'b1010 and FLAG_WE=4'hF -> stack top=4'b0101, OUT=4'b1010, LEVEL=1. Then pulse F_RESTORE -> OUT=4'b0101, LEVEL=0, STACK_EMPTY=1.
- Push 4'h1, 4'h2, 4'h3, 4'h4 (DEPTH=4) -> STACK_FULL=1. A fifth F_SAVE -> OVF_ERR=1, LEVEL stays 4. Four restores -> OUT sequence 4'h4, 4'h3, 4'h2, 4'h1.
- F_RESTORE at LEVEL=0 with FLAG_WE=4'b0001 and FLAGS_IN=4'b0001 -> UNF_ERR=1, OUT bit0=1. ERR_CLR next cycle -> UNF_ERR=0.
- LEVEL=1 with top 4'h6 and OUT=4'h9, assert F_SAVE and F_RESTORE together -> OUT=4'h6, top=4'h9, LEVEL=1.
- Assert RST mid-sequence at LEVEL=3 with OVF_ERR=1 -> next cycle OUT=0, LEVEL=0, both errors 0. A subsequent F_RESTORE -> UNF_ERR=1.
